icache_miss_queue: RTL
======================

# icache_miss_queue

Per-core instruction-cache miss tracker between the ifetch data stage and the L2 interface. Records each warp's icache miss, merges misses to the same cache line, issues one L2 line request per distinct line, and, when the L2 response for a line arrives, raises the wake bitmap that returns every warp waiting on that line to the ifetch tag stage's fetchable set. It is the responder end of the ifetch miss/sleep/wake protocol.

## Interface
- NUM_WARP_PER_CORE, 4, warps per core; also the number of queue entries.
- NUM_WARP_PER_CORE_LOG, 2, log2 of NUM_WARP_PER_CORE.
- ADDR_WIDTH, 32, byte address width.
- CACHE_LINE_BYTE_WIDTH_LOG, 6, log2 of the line size in bytes; LINE_W = ADDR_WIDTH - CACHE_LINE_BYTE_WIDTH_LOG.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset: one clock; reset is synchronous and active-high.
- ifd_cache_miss  in  1  ifetch data stage reports a true miss this cycle. Near-misses are not presented here.
- ifd_cache_miss_warp_idx  in  NUM_WARP_PER_CORE_LOG  missing warp.
- ifd_cache_miss_addr  in  ADDR_WIDTH  missing PC; low CACHE_LINE_BYTE_WIDTH_LOG bits ignored.
- l2i_req_valid  out  1  line request to L2 valid.
- l2i_req_ready  in  1  L2 accepts request.
- l2i_req_addr  out  ADDR_WIDTH  line-aligned request address (low bits 0).
- l2_resp_valid  in  1  L2 line response/fill this cycle.
- l2_resp_addr  in  ADDR_WIDTH  response line address; low bits ignored.
- l2i_to_ift_wake_bitmap  out  NUM_WARP_PER_CORE  one-cycle pulse, bit w = wake warp w.

## Operation
- Entry state, per entry e: valid, issued, line[LINE_W], wait_bitmap[NUM_WARP_PER_CORE]. Request register: req_pend (drives l2i_req_valid), req_idx.
- Capacity: each warp has at most one outstanding miss, because the tag stage stops fetching a sleeping warp. NUM_WARP_PER_CORE entries can therefore never overflow, and there is no backpressure on the miss input. A miss from a warp already set in any wait_bitmap is a protocol violation; the bench flags it with an assertion.
- Miss, line matches a valid entry: OR the warp's one-hot into that entry's wait_bitmap. This applies whether the entry is issued or not. No new request is made.
- Miss, no match: allocate the lowest-index free entry. Free status is evaluated at the start of the cycle, so an entry freed this cycle is not reused this cycle. Set valid=1, issued=0, line, wait_bitmap=warp one-hot.
- Request selection: when req_pend=0 and any entry is valid&~issued, load req_idx with the lowest such index and set req_pend=1.
- While req_pend=1, l2i_req_addr = {line[req_idx], zeros}. This is held stable until l2i_req_valid&l2i_req_ready.
- On accept: issued[req_idx]=1 and req_pend=0.
- Response: if l2_resp_valid and its line matches a valid&issued entry, register wake = wait_bitmap | (a same-cycle miss to that line from the ifd, as one-hot). Then clear that entry. If there is no match, wake = 0 and no state changes; the response is ignored.
- A same-cycle miss whose line matches the entry being freed must not allocate a new entry.
- Reset values: all valid=0, issued=0, req_pend=0, l2i_req_valid=0, l2i_req_addr=0, l2i_to_ift_wake_bitmap=0.
- Reset mid-operation discards all outstanding misses. Later responses find no match and are ignored.

## Timing
- Miss in cycle N: entry visible in N+1. l2i_req_valid rises earliest in N+2.
- Request accepted in cycle A: l2i_req_valid is low in A+1. The next request is earliest A+2, giving a maximum of one request per 2 cycles.
- Response in cycle R: l2i_to_ift_wake_bitmap is nonzero in R+1 only, for exactly one cycle. The entry is free from R+1.
- With ready=1 and one miss: request at N+2, accepted at N+2. A response at R≥N+3 gives wake at R+1.

## Test plan
- Reset, then idle for 10 cycles → l2i_req_valid=0 and wake=0 throughout.
- Warp 2 misses at 0x1044, ready=1 → l2i_req_addr=0x1040 two cycles later. Response 0x1040 → wake=4'b0100 for one cycle.
- Warp 0 misses at 0x2000, then warp 3 misses at 0x2010 before the response arrives → exactly one request, to 0x2000. Response → wake=4'b1001.
- Warps 0–3 miss at four distinct lines on consecutive cycles, with ready held 0 for 5 cycles → the first request is held stable, and requests go out in entry order. Responses returned in reverse order → each wake matches its own warp only.
- Response 0x3000 arrives in the same cycle warp 1 misses at 0x3008, while warp 0 waits on 0x3000 → wake=4'b0011, and no new entry or request is created.
- Unmatched response 0x9000, and separately, reset asserted while a request is outstanding → wake=0; after reset the response is ignored and no request reappears.

Source files
------------

// File: rtl/icache_miss_queue.sv
// icache_miss_queue: per-core icache miss tracker. Merges warp misses by
// cache line, issues one L2 line request per distinct line, and pulses a
// wake bitmap for every warp waiting on a line when its fill returns.
//
// Request handshake: l2i_req_valid/l2i_req_addr are driven from registers.
// Once valid is high, the address is held until a cycle with valid & ready.
// The request is consumed in that cycle, and valid is low in the next cycle.
module icache_miss_queue #(
  parameter int NUM_WARP_PER_CORE         = 4,
  parameter int NUM_WARP_PER_CORE_LOG     = 2,
  parameter int ADDR_WIDTH                = 32,
  parameter int CACHE_LINE_BYTE_WIDTH_LOG = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             ifd_cache_miss,
  input  logic [NUM_WARP_PER_CORE_LOG-1:0] ifd_cache_miss_warp_idx,
  input  logic [ADDR_WIDTH-1:0]            ifd_cache_miss_addr,
  output logic                             l2i_req_valid,
  input  logic                             l2i_req_ready,
  output logic [ADDR_WIDTH-1:0]            l2i_req_addr,
  input  logic                             l2_resp_valid,
  input  logic [ADDR_WIDTH-1:0]            l2_resp_addr,
  output logic [NUM_WARP_PER_CORE-1:0]     l2i_to_ift_wake_bitmap
);

  localparam int OFF_W  = CACHE_LINE_BYTE_WIDTH_LOG;
  localparam int LINE_W = ADDR_WIDTH - CACHE_LINE_BYTE_WIDTH_LOG;
  localparam int NW     = NUM_WARP_PER_CORE;
  localparam int IW     = NUM_WARP_PER_CORE_LOG;

  // Entry state
  logic [NW-1:0]     r_valid;
  logic [NW-1:0]     r_issued;
  logic [LINE_W-1:0] r_line [NW];
  logic [NW-1:0]     r_wait [NW];

  // Request register
  logic              r_req_pend;
  logic [IW-1:0]     r_req_idx;
  logic [ADDR_WIDTH-1:0] r_req_addr;

  // Wake pulse register
  logic [NW-1:0]     r_wake;

  // Decoded inputs
  logic [LINE_W-1:0] w_miss_line;
  logic [LINE_W-1:0] w_resp_line;
  logic [NW-1:0]     w_miss_onehot;
  logic              w_unused_low_bits;

  // Match / selection results
  logic [NW-1:0]     w_miss_match;
  logic              w_miss_hit;
  logic [IW-1:0]     w_miss_idx;
  logic [NW-1:0]     w_free;
  logic              w_free_any;
  logic [IW-1:0]     w_alloc_idx;
  logic [NW-1:0]     w_resp_match;
  logic              w_resp_hit;
  logic [IW-1:0]     w_resp_idx;
  logic [NW-1:0]     w_cand;
  logic              w_cand_any;
  logic [IW-1:0]     w_cand_idx;
  logic              w_req_fire;
  logic              w_miss_on_resp_line;
  logic [NW-1:0]     w_wake_next;

  assign w_miss_line       = ifd_cache_miss_addr[ADDR_WIDTH-1:OFF_W];
  assign w_resp_line       = l2_resp_addr[ADDR_WIDTH-1:OFF_W];
  assign w_miss_onehot     = NW'(1) << ifd_cache_miss_warp_idx;
  // Byte offsets within a line carry no information for this block.
  assign w_unused_low_bits = ^{ifd_cache_miss_addr[OFF_W-1:0], l2_resp_addr[OFF_W-1:0]};
  assign w_req_fire        = r_req_pend & l2i_req_ready;

  // Per-entry line compares against the incoming miss and the incoming response.
  always_comb begin
    w_miss_match = '0;
    w_resp_match = '0;
    w_free       = '0;
    w_cand       = '0;
    for (int e = 0; e < NW; e++) begin
      w_miss_match[e] = r_valid[e] && (r_line[e] == w_miss_line);
      w_resp_match[e] = l2_resp_valid && r_valid[e] && r_issued[e] &&
                        (r_line[e] == w_resp_line);
      w_free[e]       = ~r_valid[e];
      w_cand[e]       = r_valid[e] & ~r_issued[e];
    end
  end

  // Lowest-index pick for each vector; scanning downward leaves the lowest set bit.
  always_comb begin
    w_miss_idx  = '0;
    w_alloc_idx = '0;
    w_resp_idx  = '0;
    w_cand_idx  = '0;
    for (int e = NW - 1; e >= 0; e--) begin
      if (w_miss_match[e]) w_miss_idx  = IW'(e);
      if (w_free[e])       w_alloc_idx = IW'(e);
      if (w_resp_match[e]) w_resp_idx  = IW'(e);
      if (w_cand[e])       w_cand_idx  = IW'(e);
    end
  end

  assign w_miss_hit = |w_miss_match;
  assign w_free_any = |w_free;
  assign w_resp_hit = |w_resp_match;
  assign w_cand_any = |w_cand;

  // A miss arriving with the fill of its own line is woken directly rather than queued.
  assign w_miss_on_resp_line = ifd_cache_miss && (w_miss_line == w_resp_line);

  // Wake bitmap for the coming cycle: waiting warps plus any same-cycle joiner.
  always_comb begin
    w_wake_next = '0;
    if (w_resp_hit) begin
      w_wake_next = r_wait[w_resp_idx] | (w_miss_on_resp_line ? w_miss_onehot : '0);
    end
  end

  // Entry table: merge or allocate on miss, mark issued on accept, free on fill.
  // The free at the end takes priority, so a miss merged into a line being
  // filled this cycle leaves no entry behind (it is covered by the wake).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= '0;
      r_issued <= '0;
      for (int e = 0; e < NW; e++) begin
        r_line[e] <= '0;
        r_wait[e] <= '0;
      end
    end else begin
      if (w_req_fire) begin
        r_issued[r_req_idx] <= 1'b1;
      end
      if (ifd_cache_miss && w_miss_hit) begin
        r_wait[w_miss_idx] <= r_wait[w_miss_idx] | w_miss_onehot;
      end else if (ifd_cache_miss && w_free_any) begin
        r_valid[w_alloc_idx]  <= 1'b1;
        r_issued[w_alloc_idx] <= 1'b0;
        r_line[w_alloc_idx]   <= w_miss_line;
        r_wait[w_alloc_idx]   <= w_miss_onehot;
      end
      if (w_resp_hit) begin
        r_valid[w_resp_idx]  <= 1'b0;
        r_issued[w_resp_idx] <= 1'b0;
        r_wait[w_resp_idx]   <= '0;
      end
    end
  end

  // Request register: load the lowest unissued entry when idle, drop on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_pend <= 1'b0;
      r_req_idx  <= '0;
      r_req_addr <= '0;
    end else if (r_req_pend) begin
      if (l2i_req_ready) begin
        r_req_pend <= 1'b0;
      end
    end else if (w_cand_any) begin
      r_req_pend <= 1'b1;
      r_req_idx  <= w_cand_idx;
      r_req_addr <= {r_line[w_cand_idx], {OFF_W{1'b0}}};
    end
  end

  // Wake pulse: registered one cycle after the matching fill, zero otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wake <= '0;
    end else begin
      r_wake <= w_wake_next;
    end
  end

  assign l2i_req_valid          = r_req_pend;
  assign l2i_req_addr           = r_req_addr;
  assign l2i_to_ift_wake_bitmap = r_wake;

endmodule
